bus_sync_launch: RTL

Source-domain launcher for the multi-bit stability-filter synchronizer. Accepts words from a source-clock producer over a valid/ready handshake, drives them from a dedicated launch register, and holds each word unchanged for a programmable minimum number of source cycles. This ensures the destination-side filter always sees two equal consecutive samples. Sits directly in front of the destination synchronizer's data input; its output is the only thing allowed to cross the clock boundary.

---
 rtl/bus_sync_launch.sv | 137 +++++++++++++
 1 files changed

// File: rtl/bus_sync_launch.sv
// Source-side launch register for the stability-filter synchronizer; optional latest-value mode via BUS_SYNC_LAUNCH_COALESCE_EN.
// Latency: transfer at edge N is on o_data_a with o_launch high in cycle N+1; each word is held HOLD_CYCLES cycles.
// Backpressure: lossless mode deasserts o_ready during the hold window; coalesce mode is always ready and keeps the newest word.
module bus_sync_launch #(
    parameter int BUS_WIDTH   = 1,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                 i_clk_a,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [BUS_WIDTH-1:0] i_data,
    output logic [BUS_WIDTH-1:0] o_data_a,
    output logic                 o_launch,
    output logic                 o_busy,
    output logic                 o_overwrite
);

    localparam int CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    if (HOLD_CYCLES < 2) begin : g_hold_chk
        $error("bus_sync_launch: HOLD_CYCLES must be >= 2");
    end

    logic [0:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0] data_q, data_d;
    logic                 launch_q, launch_d;
    logic                 hold_end;
    logic                 can_launch;
    logic                 xfer;

    assign hold_end   = (state_q == S_HOLD) && (cnt_q == '0);
    assign can_launch = (state_q == S_IDLE) || hold_end;
    assign xfer       = i_valid && o_ready;

    assign o_data_a = data_q;
    assign o_launch = launch_q;
    assign o_busy   = (state_q == S_HOLD);

`ifdef BUS_SYNC_LAUNCH_COALESCE_EN
    logic                 pend_vld_q, pend_vld_d;
    logic [BUS_WIDTH-1:0] pend_dat_q, pend_dat_d;
    logic                 ovw_q, ovw_d;

    assign o_ready     = 1'b1;
    assign o_overwrite = ovw_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        launch_d   = 1'b0;
        pend_vld_d = pend_vld_q;
        pend_dat_d = pend_dat_q;
        ovw_d      = 1'b0;
        if (can_launch) begin
            // A word arriving in the launch slot beats the older pending one.
            if (xfer) begin
                state_d    = S_HOLD;
                cnt_d      = RELOAD;
                data_d     = i_data;
                launch_d   = 1'b1;
                pend_vld_d = 1'b0;
            end else if (pend_vld_q) begin
                state_d    = S_HOLD;
                cnt_d      = RELOAD;
                data_d     = pend_dat_q;
                launch_d   = 1'b1;
                pend_vld_d = 1'b0;
            end else begin
                state_d = S_IDLE;
            end
        end else begin
            cnt_d = cnt_q - CW'(1);
            if (xfer) begin
                pend_dat_d = i_data;
                pend_vld_d = 1'b1;
                ovw_d      = pend_vld_q;
            end
        end
    end

    always_ff @(posedge i_clk_a or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_vld_q <= 1'b0;
            pend_dat_q <= '0;
            ovw_q      <= 1'b0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_dat_q <= pend_dat_d;
            ovw_q      <= ovw_d;
        end
    end
`else
    assign o_ready     = can_launch;
    assign o_overwrite = 1'b0;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        launch_d = 1'b0;
        if (can_launch) begin
            if (xfer) begin
                state_d  = S_HOLD;
                cnt_d    = RELOAD;
                data_d   = i_data;
                launch_d = 1'b1;
            end else begin
                state_d = S_IDLE;
            end
        end else begin
            cnt_d = cnt_q - CW'(1);
        end
    end
`endif

    always_ff @(posedge i_clk_a or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            launch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            launch_q <= launch_d;
        end
    end

endmodule
